// File: rtl/if_prefetch_unit.sv
// Decoupled instruction prefetcher: issues sequential word fetches on a req/gnt
// memory port, buffers {pc, instr} pairs in a FIFO and hands them to decode with
// a valid/ready handshake. A redirect flushes the buffer and drops in-flight data.
module if_prefetch_unit #(
  parameter int unsigned                 XLEN            = 32,
  parameter int unsigned                 IMEM_ADDR_WIDTH = 32,
  parameter int unsigned                 FIFO_DEPTH      = 4,
  parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       EX_PC_source_sel,
  input  logic [IMEM_ADDR_WIDTH-1:0] EX_PC_branch_dest,
  output logic                       IMEM_req,
  output logic [IMEM_ADDR_WIDTH-1:0] IMEM_addr,
  input  logic                       IMEM_gnt,
  input  logic                       IMEM_rvalid,
  input  logic [XLEN-1:0]            IMEM_rdata,
  input  logic                       ID_ready,
  output logic                       IF_valid,
  output logic [IMEM_ADDR_WIDTH-1:0] IF_PC,
  output logic [XLEN-1:0]            IF_Instruction
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [IMEM_ADDR_WIDTH-1:0] WordInc = IMEM_ADDR_WIDTH'(4);

  logic [IMEM_ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_next;
  logic [IMEM_ADDR_WIDTH-1:0] r_resp_pc, w_resp_pc_next;
  logic [CntW-1:0]            r_outstanding, w_outstanding_next;
  logic [CntW-1:0]            r_drop_cnt, w_drop_cnt_next;
  logic [CntW-1:0]            r_count, w_count_next;
  logic [PtrW-1:0]            r_wr_ptr, w_wr_ptr_next;
  logic [PtrW-1:0]            r_rd_ptr, w_rd_ptr_next;
  logic [IMEM_ADDR_WIDTH-1:0] r_pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0]            r_instr_mem [FIFO_DEPTH];

  logic                       w_grant, w_rsp, w_drop, w_push, w_pop, w_credit;
  logic [IMEM_ADDR_WIDTH-1:0] w_target;

  // Credit and handshake qualifiers
  always_comb begin
    // Masking keeps all target bits in use while forcing word alignment
    w_target = EX_PC_branch_dest & ~IMEM_ADDR_WIDTH'(3);
    w_credit = (SumW'(r_outstanding) + SumW'(r_count)) < SumW'(FIFO_DEPTH);
    IMEM_req = !Reset && !EX_PC_source_sel && w_credit;
    IMEM_addr = r_fetch_pc;
    w_grant  = IMEM_req && IMEM_gnt;
    // A response with nothing outstanding belongs to a pre-reset request
    w_rsp    = IMEM_rvalid && (r_outstanding != '0);
    w_drop   = w_rsp && (EX_PC_source_sel || (r_drop_cnt != '0));
    w_push   = w_rsp && !w_drop;
    w_pop    = (r_count != '0) && ID_ready && !EX_PC_source_sel;
  end

  // Next-state for PCs, credit counters and FIFO pointers; redirect wins
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_grant && !w_rsp) begin
      w_outstanding_next = r_outstanding + CntW'(1);
    end else if (!w_grant && w_rsp) begin
      w_outstanding_next = r_outstanding - CntW'(1);
    end

    w_fetch_pc_next = r_fetch_pc;
    w_resp_pc_next  = r_resp_pc;
    w_drop_cnt_next = r_drop_cnt;
    w_count_next    = r_count;
    w_wr_ptr_next   = r_wr_ptr;
    w_rd_ptr_next   = r_rd_ptr;

    if (EX_PC_source_sel) begin
      w_fetch_pc_next = w_target;
      w_resp_pc_next  = w_target;
      // Everything still in flight after this cycle belongs to the old stream
      w_drop_cnt_next = r_outstanding - CntW'(w_rsp);
      w_count_next    = '0;
      w_wr_ptr_next   = '0;
      w_rd_ptr_next   = '0;
    end else begin
      if (w_grant) w_fetch_pc_next = r_fetch_pc + WordInc;
      if (w_push)  w_resp_pc_next  = r_resp_pc + WordInc;
      if (w_rsp && (r_drop_cnt != '0)) w_drop_cnt_next = r_drop_cnt - CntW'(1);
      if (w_push)  w_wr_ptr_next   = r_wr_ptr + PtrW'(1);
      if (w_pop)   w_rd_ptr_next   = r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        w_count_next = r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        w_count_next = r_count - CntW'(1);
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_next;
      r_resp_pc     <= w_resp_pc_next;
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= w_drop_cnt_next;
      r_count       <= w_count_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_rd_ptr      <= w_rd_ptr_next;
    end
  end

  // FIFO storage; contents need no reset since r_count gates visibility
  always_ff @(posedge Clk) begin
    if (w_push && !Reset) begin
      r_pc_mem[r_wr_ptr]    <= r_resp_pc;
      r_instr_mem[r_wr_ptr] <= IMEM_rdata;
    end
  end

  // Head-of-FIFO presentation to decode
  always_comb begin
    IF_valid       = r_count != '0;
    IF_PC          = r_pc_mem[r_rd_ptr];
    IF_Instruction = r_instr_mem[r_rd_ptr];
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: behavioural memory with programmable latency,
// expected {pc, instr} scoreboard drained by a monitor on accepted handshakes,
// plus directed cycle-accurate checks of requests, latency and redirect behaviour.
module tb_if_prefetch_unit;

  logic        Clk;
  logic        Reset;
  logic        EX_PC_source_sel;
  logic [31:0] EX_PC_branch_dest;
  logic        IMEM_req;
  logic [31:0] IMEM_addr;
  logic        IMEM_gnt;
  logic        IMEM_rvalid;
  logic [31:0] IMEM_rdata;
  logic        ID_ready;
  logic        IF_valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instruction;

  if_prefetch_unit #(
    .XLEN           (32),
    .IMEM_ADDR_WIDTH(32),
    .FIFO_DEPTH     (4),
    .RESET_PC       (32'h0)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .EX_PC_source_sel (EX_PC_source_sel),
    .EX_PC_branch_dest(EX_PC_branch_dest),
    .IMEM_req         (IMEM_req),
    .IMEM_addr        (IMEM_addr),
    .IMEM_gnt         (IMEM_gnt),
    .IMEM_rvalid      (IMEM_rvalid),
    .IMEM_rdata       (IMEM_rdata),
    .ID_ready         (ID_ready),
    .IF_valid         (IF_valid),
    .IF_PC            (IF_PC),
    .IF_Instruction   (IF_Instruction)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    int          due;
  } mreq_t;

  exp_t  sb[$];
  mreq_t mq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_deliv = 0;
  int    n_gnt   = 0;
  int    lat     = 1;
  int    ecnt    = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      sb.push_back('{pc: pc, ins: mem_word(pc)});
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Memory model: in-order responses, rvalid lat cycles after the grant cycle
  always @(posedge Clk) begin
    ecnt = ecnt + 1;
    if (Reset) begin
      mq.delete();
      IMEM_rvalid <= 1'b0;
    end else begin
      if (IMEM_req && IMEM_gnt) begin
        mq.push_back('{a: IMEM_addr, due: ecnt + lat});
        n_gnt++;
      end
      if (mq.size() > 0 && mq[0].due <= ecnt + 1) begin
        IMEM_rvalid <= 1'b1;
        IMEM_rdata  <= mem_word(mq[0].a);
        void'(mq.pop_front());
      end else begin
        IMEM_rvalid <= 1'b0;
      end
    end
  end

  // Monitor: every accepted head entry must be the next expected one
  always @(negedge Clk) begin
    if (!Reset && IF_valid && ID_ready && !EX_PC_source_sel) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, expected no delivery", IF_PC);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", IF_PC, e.pc);
        chk("sb_instr", IF_Instruction, e.ins);
        n_deliv++;
      end
    end
  end

  // Holds reset two edges, then releases it; caller is left in cycle 0
  task automatic do_reset();
    Reset = 1'b1;
    EX_PC_source_sel = 1'b0;
    tick();
    tick();
    chk("rst_req", IMEM_req, 0);
    chk("rst_valid", IF_valid, 0);
    sb.delete();
    n_deliv = 0;
    n_gnt   = 0;
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    EX_PC_source_sel = 1'b0;
    EX_PC_branch_dest = '0;
    IMEM_gnt = 1'b1;
    IMEM_rdata = '0;
    ID_ready = 1'b0;

    // Streaming with 1-cycle memory
    lat = 1; ID_ready = 1'b1;
    do_reset();
    push_seq(32'h0, 40);
    chk("t1_req0", IMEM_req, 1);
    chk("t1_addr0", IMEM_addr, 32'h0);
    tick();
    chk("t1_addr1", IMEM_addr, 32'h4);
    chk("t1_valid_c1", IF_valid, 0);
    tick();
    chk("t1_addr2", IMEM_addr, 32'h8);
    chk("t1_valid_c2", IF_valid, 1);
    chk("t1_pc_c2", IF_PC, 32'h0);
    tick();
    chk("t1_pc_c3", IF_PC, 32'h4);
    repeat (8) tick();
    chk("t1_deliv", n_deliv, 9);

    // Backpressure fills the FIFO and stops requests
    lat = 1; ID_ready = 1'b0;
    do_reset();
    push_seq(32'h0, 40);
    repeat (8) tick();
    chk("t2_grants", n_gnt, 4);
    chk("t2_req_off", IMEM_req, 0);
    chk("t2_valid", IF_valid, 1);
    chk("t2_head", IF_PC, 32'h0);
    ID_ready = 1'b1;
    #1;
    chk("t2_req_still_off", IMEM_req, 0);
    tick();
    chk("t2_req_back", IMEM_req, 1);
    chk("t2_addr_back", IMEM_addr, 32'h10);
    repeat (6) tick();
    chk("t2_deliv", (n_deliv >= 4) ? 1 : 0, 1);

    // Redirect with three requests outstanding on a 3-cycle memory
    lat = 3; ID_ready = 1'b1;
    do_reset();
    push_seq(32'h100, 30);
    repeat (3) tick();
    EX_PC_source_sel = 1'b1; EX_PC_branch_dest = 32'h103;
    #1;
    chk("t3_req_redirect", IMEM_req, 0);
    tick();
    EX_PC_source_sel = 1'b0;
    #1;
    chk("t3_req_new", IMEM_req, 1);
    chk("t3_addr_new", IMEM_addr, 32'h100);
    chk("t3_valid_c4", IF_valid, 0);
    repeat (3) tick();
    chk("t3_valid_c7", IF_valid, 0);
    tick();
    chk("t3_valid_c8", IF_valid, 1);
    chk("t3_pc_c8", IF_PC, 32'h100);
    repeat (6) tick();
    chk("t3_deliv", (n_deliv >= 3) ? 1 : 0, 1);

    // Redirect coinciding with rvalid and a pop, two entries buffered
    lat = 2; ID_ready = 1'b0;
    do_reset();
    push_seq(32'h400, 30);
    repeat (4) tick();
    chk("t4_valid_pre", IF_valid, 1);
    chk("t4_req_pre", IMEM_req, 0);
    EX_PC_source_sel = 1'b1; EX_PC_branch_dest = 32'h400; ID_ready = 1'b1;
    #1;
    tick();
    EX_PC_source_sel = 1'b0;
    #1;
    chk("t4_valid_c5", IF_valid, 0);
    chk("t4_req_c5", IMEM_req, 1);
    chk("t4_addr_c5", IMEM_addr, 32'h400);
    tick();
    chk("t4_valid_c6", IF_valid, 0);
    tick();
    chk("t4_valid_c7", IF_valid, 0);
    tick();
    chk("t4_valid_c8", IF_valid, 1);
    chk("t4_pc_c8", IF_PC, 32'h400);
    repeat (5) tick();
    chk("t4_deliv", (n_deliv >= 3) ? 1 : 0, 1);

    // Back-to-back redirects: only the second target's stream survives
    lat = 1; ID_ready = 1'b1;
    do_reset();
    push_seq(32'h0, 2);
    push_seq(32'h300, 30);
    repeat (4) tick();
    EX_PC_source_sel = 1'b1; EX_PC_branch_dest = 32'h200;
    #1;
    chk("t5_req_r1", IMEM_req, 0);
    tick();
    EX_PC_branch_dest = 32'h300;
    #1;
    chk("t5_req_r2", IMEM_req, 0);
    tick();
    EX_PC_source_sel = 1'b0;
    #1;
    chk("t5_req_new", IMEM_req, 1);
    chk("t5_addr_new", IMEM_addr, 32'h300);
    chk("t5_valid_c6", IF_valid, 0);
    repeat (2) tick();
    chk("t5_valid_c8", IF_valid, 1);
    chk("t5_pc_c8", IF_PC, 32'h300);
    repeat (4) tick();
    chk("t5_deliv", n_deliv, 6);

    // Address wrap, then reset mid-stream
    lat = 1; ID_ready = 1'b1;
    do_reset();
    push_seq(32'hFFFF_FFFC, 30);
    EX_PC_source_sel = 1'b1; EX_PC_branch_dest = 32'hFFFF_FFFE;
    #1;
    chk("t6_req_r", IMEM_req, 0);
    tick();
    EX_PC_source_sel = 1'b0;
    #1;
    chk("t6_addr_top", IMEM_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_addr_wrap", IMEM_addr, 32'h0);
    repeat (6) tick();
    chk("t6_deliv", n_deliv, 5);
    chk("t6_valid_pre", IF_valid, 1);
    Reset = 1'b1;
    #1;
    chk("t6_req_rst", IMEM_req, 0);
    tick();
    chk("t6_valid_rst", IF_valid, 0);
    sb.delete();
    n_deliv = 0;
    push_seq(32'h0, 30);
    Reset = 1'b0;
    #1;
    chk("t6_req_restart", IMEM_req, 1);
    chk("t6_addr_restart", IMEM_addr, 32'h0);
    repeat (2) tick();
    chk("t6_valid_restart", IF_valid, 1);
    chk("t6_pc_restart", IF_PC, 32'h0);
    repeat (4) tick();
    chk("t6_deliv_restart", n_deliv, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
